// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract unit with valid/ready handshakes.
// Operands are cut into STAGES slices of WIDTH/STAGES bits. Stage i resolves
// slice i and hands its carry to stage i+1. The A operand and the partial sum
// share one word that travels down the pipe: slices below i hold result bits,
// slices from i upward still hold A. The unconsumed upper slices of Bx travel
// in a packed skew chain whose segment for stage i holds only the slices that
// stage i+1 and later still need. One enable (adv) moves the whole pipe, so
// there is no control state machine.
module adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cIn,
    input  logic             sub,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] sum,
    output logic             cOut,
    output logic             ovf
);

    localparam int SLICE = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] bx;

    // Per-stage registers: A/partial-sum word, slice carry, valid bit.
    logic [WIDTH-1:0] x_reg     [STAGES];
    logic             carry_reg [STAGES];
    logic             valid_reg [STAGES];
    logic             ovf_reg;

    assign bx       = sub ? ~B : B;
    // The pipe moves whenever the last stage is empty or being drained.
    assign adv      = !valid_reg[STAGES-1] || outReady;
    assign inReady  = adv;
    assign outValid = valid_reg[STAGES-1];
    assign sum      = x_reg[STAGES-1];
    assign cOut     = carry_reg[STAGES-1];
    assign ovf      = ovf_reg;

    if (STAGES == 1) begin : g_single
        logic [WIDTH:0] full_next;
        logic           ovf_next;

        assign full_next = {1'b0, A} + {1'b0, bx} + {{WIDTH{1'b0}}, cIn};
        assign ovf_next  = (A[WIDTH-1] == bx[WIDTH-1]) &&
                           (full_next[WIDTH-1] != A[WIDTH-1]);

        // Single register stage capturing the full-width result.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg[0] <= 1'b0;
                x_reg[0]     <= '0;
                carry_reg[0] <= 1'b0;
                ovf_reg      <= 1'b0;
            end else if (adv) begin
                valid_reg[0] <= inValid;
                x_reg[0]     <= full_next[WIDTH-1:0];
                carry_reg[0] <= full_next[WIDTH];
                ovf_reg      <= ovf_next;
            end
        end
    end else begin : g_multi
        // Segment i of the skew chain holds Bx slices i+1..STAGES-1.
        localparam int SKEW_W = SLICE * STAGES * (STAGES - 1) / 2;
        logic [SKEW_W-1:0] skew_reg;

        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LO    = gi * SLICE;
            localparam int OFF_P = (gi == 0) ? 0 :
                                   (gi - 1) * WIDTH - SLICE * (gi - 1) * gi / 2;

            logic [WIDTH-1:0] x_in;
            logic [WIDTH-1:0] x_next;
            logic [SLICE-1:0] a_sl;
            logic [SLICE-1:0] b_sl;
            logic [SLICE-1:0] s_sl;
            logic             v_in;
            logic             c_in;
            logic             c_out;

            if (gi == 0) begin : g_first
                assign x_in = A;
                assign v_in = inValid;
                assign c_in = cIn;
                assign b_sl = bx[SLICE-1:0];
            end else begin : g_follow
                assign x_in = x_reg[gi-1];
                assign v_in = valid_reg[gi-1];
                assign c_in = carry_reg[gi-1];
                assign b_sl = skew_reg[OFF_P +: SLICE];
            end

            assign a_sl          = x_in[LO +: SLICE];
            assign {c_out, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, c_in};

            // Replace the consumed A slice with its result slice.
            always_comb begin
                x_next             = x_in;
                x_next[LO +: SLICE] = s_sl;
            end

            // Stage register: word, carry and valid advance together.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    x_reg[gi]     <= '0;
                    carry_reg[gi] <= 1'b0;
                end else if (adv) begin
                    valid_reg[gi] <= v_in;
                    x_reg[gi]     <= x_next;
                    carry_reg[gi] <= c_out;
                end
            end

            if (gi < STAGES - 1) begin : g_skew
                localparam int OFF = gi * WIDTH - SLICE * gi * (gi + 1) / 2;
                localparam int RW  = WIDTH - (gi + 1) * SLICE;

                if (gi == 0) begin : g_from_port
                    // Park the upper Bx slices that later stages still need.
                    always_ff @(posedge clk) begin
                        if (adv) begin
                            skew_reg[OFF +: RW] <= bx[WIDTH-1:SLICE];
                        end
                    end
                end else begin : g_from_prev
                    // Drop the slice this stage consumed, pass the rest on.
                    always_ff @(posedge clk) begin
                        if (adv) begin
                            skew_reg[OFF +: RW] <= skew_reg[OFF_P + SLICE +: RW];
                        end
                    end
                end
            end else begin : g_last
                // Signed overflow is judged on the MSB slice, held in A's top bit.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        ovf_reg <= 1'b0;
                    end else if (adv) begin
                        ovf_reg <= (x_in[WIDTH-1] == b_sl[SLICE-1]) &&
                                   (s_sl[SLICE-1] != x_in[WIDTH-1]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe, run on three configurations side by side:
// cfg0 WIDTH=8/STAGES=2, cfg1 WIDTH=16/STAGES=4, cfg2 WIDTH=8/STAGES=1.
// Each driver pushes the expected result when an operand is accepted; each
// monitor pops and compares whenever the DUT presents a result.
module tb_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] esum;
        logic        ecout;
        logic        eovf;
    } op_t;

    typedef struct {
        logic rst;
        logic iv;
        logic ordy;
    } cyc_t;

    typedef struct {
        logic [15:0] esum;
        logic        ecout;
        logic        eovf;
        int          acc_cyc;
        int          acc_stall;
    } exp_t;

    task automatic check(input int cfg, input string nm,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got 0x%0h expected 0x%0h", cfg, nm, act, exp);
        end
    endtask

    task automatic mark_done;
        done_cnt++;
    endtask

    function automatic op_t dir(input logic [15:0] a, input logic [15:0] b,
                                input logic cin, input logic sub,
                                input logic [15:0] es, input logic ec, input logic eo);
        op_t o;
        o.a = a; o.b = b; o.cin = cin; o.sub = sub;
        o.esum = es; o.ecout = ec; o.eovf = eo;
        return o;
    endfunction

    // Whole-word arithmetic reference for random operands.
    function automatic op_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub);
        op_t o;
        int  mask, av, bv, s, am, bm, sm;
        mask = (1 << w) - 1;
        av   = int'(a) & mask;
        bv   = (sub ? ~int'(b) : int'(b)) & mask;
        s    = av + bv + (cin ? 1 : 0);
        am   = (av >> (w - 1)) & 1;
        bm   = (bv >> (w - 1)) & 1;
        sm   = (s >> (w - 1)) & 1;
        o.a = 16'(av); o.b = b; o.cin = cin; o.sub = sub;
        o.esum  = 16'(s & mask);
        o.ecout = ((s >> w) & 1) != 0;
        o.eovf  = (am == bm) && (sm != am);
        return o;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int CW = (gi == 1) ? 16 : 8;
        localparam int CS = (gi == 0) ? 2 : ((gi == 1) ? 4 : 1);

        logic          rst = 1'b1;
        logic          in_valid = 1'b0;
        logic          in_ready;
        logic          c_in = 1'b0;
        logic          sub_op = 1'b0;
        logic          out_valid;
        logic          out_ready = 1'b1;
        logic          c_out;
        logic          ovf;
        logic [CW-1:0] a = '0;
        logic [CW-1:0] b = '0;
        logic [CW-1:0] sum;

        exp_t sb[$];
        int   cyc = 0;
        int   stall_cnt = 0;
        logic prev_rst = 1'b0;

        adder_pipe #(.WIDTH(CW), .STAGES(CS)) dut (
            .clk(clk), .rst(rst),
            .inValid(in_valid), .inReady(in_ready),
            .A(a), .B(b), .cIn(c_in), .sub(sub_op),
            .outValid(out_valid), .outReady(out_ready),
            .sum(sum), .cOut(c_out), .ovf(ovf)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Monitor: checks reset state, handshake and every presented result.
        always @(negedge clk) begin
            if (rst) begin
                prev_rst <= 1'b1;
            end else begin
                prev_rst <= 1'b0;
                if (prev_rst) begin
                    check(gi, "rst_out_valid", out_valid, 0);
                    check(gi, "rst_sum", sum, 0);
                    check(gi, "rst_cout", c_out, 0);
                    check(gi, "rst_ovf", ovf, 0);
                end
                check(gi, "in_ready", in_ready, !out_valid || out_ready);
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check(gi, "unexpected_result", out_valid, 0);
                    end else begin
                        check(gi, "sum", sum, sb[0].esum[CW-1:0]);
                        check(gi, "cout", c_out, sb[0].ecout);
                        check(gi, "ovf", ovf, sb[0].eovf);
                        if (out_ready) begin
                            check(gi, "latency", cyc - sb[0].acc_cyc,
                                  CS + stall_cnt - sb[0].acc_stall);
                            void'(sb.pop_front());
                        end else begin
                            stall_cnt <= stall_cnt + 1;
                        end
                    end
                end
            end
        end

        // Driver: replays the cycle table, offering the next operand set.
        initial begin
            op_t  ops[$];
            cyc_t cy[$];
            exp_t e;
            int   idx;
            idx = 0;

            if (CW == 16) begin
                ops.push_back(dir(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0));
                ops.push_back(dir(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0));
                ops.push_back(dir(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1));
                ops.push_back(dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
            end else begin
                ops.push_back(dir(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0));
                ops.push_back(dir(16'h0005, 16'h0007, 1'b1, 1'b1, 16'h00FE, 1'b0, 1'b0));
                ops.push_back(dir(16'h0080, 16'h0001, 1'b1, 1'b1, 16'h007F, 1'b1, 1'b1));
                ops.push_back(dir(16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1));
            end
            for (int k = 0; k < 31; k++)
                ops.push_back(model(CW, 16'($urandom), 16'($urandom),
                                    1'($urandom), 1'($urandom)));

            // Reset, then isolated directed operations.
            for (int k = 0; k < 2; k++) cy.push_back('{1'b1, 1'b0, 1'b1});
            for (int d = 0; d < 4; d++) begin
                cy.push_back('{1'b0, 1'b1, 1'b1});
                for (int k = 0; k < CS + 1; k++) cy.push_back('{1'b0, 1'b0, 1'b1});
            end
            // Back-to-back stream of 16.
            for (int k = 0; k < 16; k++) cy.push_back('{1'b0, 1'b1, 1'b1});
            for (int k = 0; k < CS + 2; k++) cy.push_back('{1'b0, 1'b0, 1'b1});
            // Stream with a 3-cycle output stall.
            for (int k = 0; k < 6; k++) cy.push_back('{1'b0, 1'b1, 1'b1});
            for (int k = 0; k < 3; k++) cy.push_back('{1'b0, 1'b1, 1'b0});
            for (int k = 0; k < 6; k++) cy.push_back('{1'b0, 1'b1, 1'b1});
            for (int k = 0; k < CS + 3; k++) cy.push_back('{1'b0, 1'b0, 1'b1});
            // Reset with operations in flight, then one fresh operation.
            for (int k = 0; k < 2; k++) cy.push_back('{1'b0, 1'b1, 1'b1});
            cy.push_back('{1'b1, 1'b1, 1'b1});
            cy.push_back('{1'b0, 1'b0, 1'b1});
            cy.push_back('{1'b0, 1'b1, 1'b1});
            for (int k = 0; k < CS + 3; k++) cy.push_back('{1'b0, 1'b0, 1'b1});

            for (int i = 0; i < cy.size(); i++) begin
                rst       = cy[i].rst;
                in_valid  = cy[i].iv && (idx < ops.size());
                out_ready = cy[i].ordy;
                if (idx < ops.size()) begin
                    a      = ops[idx].a[CW-1:0];
                    b      = ops[idx].b[CW-1:0];
                    c_in   = ops[idx].cin;
                    sub_op = ops[idx].sub;
                end
                @(negedge clk);
                if (cy[i].rst) begin
                    sb.delete();
                end else if (in_valid && in_ready) begin
                    e.esum      = ops[idx].esum;
                    e.ecout     = ops[idx].ecout;
                    e.eovf      = ops[idx].eovf;
                    e.acc_cyc   = cyc;
                    e.acc_stall = stall_cnt;
                    sb.push_back(e);
                    idx++;
                end
                @(posedge clk);
                #1;
            end
            check(gi, "results_drained", sb.size(), 0);
            check(gi, "ops_accepted", idx, ops.size());
            mark_done();
        end
    end

    initial begin
        for (int i = 0; i < 20000 && done_cnt < 3; i++) @(posedge clk);
        check(9, "all_configs_done", done_cnt, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
